// File: rtl/aurora_tx_sequencer.sv
// TX source selector and packet sequencer in front of the Aurora AXI-Stream TX port.
// Modes: off, loopback passthrough, periodic stimulus packets, delayed reply after an RX packet.
module aurora_tx_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_delay,
  input  logic [DATA_WIDTH-1:0] cfg_base,
  input  logic                  rx_tlast,
  input  logic                  s_loop_tvalid,
  input  logic [DATA_WIDTH-1:0] s_loop_tdata,
  input  logic                  s_loop_tlast,
  output logic                  s_loop_tready,
  input  logic                  s_user_tvalid,
  input  logic [DATA_WIDTH-1:0] s_user_tdata,
  input  logic                  s_user_tlast,
  output logic                  s_user_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [1:0]            active_mode,
  output logic                  busy,
  output logic [31:0]           pkt_count,
  output logic [15:0]           trig_drop
);

  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_STIM = 2'b10;
  localparam logic [1:0] MODE_TRIG = 2'b11;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, LOOP, STIM, WAIT, USER} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  period_cnt, delay_cnt, period_max;
  logic                  pending, in_pkt, launch;
  logic [LEN_WIDTH-1:0]  len_q, word_idx, len_eff;
  logic [DATA_WIDTH-1:0] base_q;
  logic                  period_hit, stim_last, beat, last_beat;

  assign period_max = (cfg_period == '0) ? '0 : cfg_period - CNT_ONE;
  assign period_hit = (cfg_mode == MODE_STIM) && (period_cnt == period_max);
  assign len_eff    = (cfg_len == '0) ? LEN_ONE : cfg_len;
  assign stim_last  = (word_idx == len_q - LEN_ONE);
  assign beat       = m_axis_tvalid & m_axis_tready;
  assign last_beat  = beat & m_axis_tlast;
  assign busy       = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    launch        = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_loop_tready = 1'b0;
    s_user_tready = 1'b0;
    case (state)
      IDLE: begin
        case (cfg_mode)
          MODE_LOOP: state_nxt = LOOP;
          MODE_STIM: if (period_hit || pending) begin
            state_nxt = STIM;
            launch    = 1'b1;
          end
          MODE_TRIG: if (rx_tlast) state_nxt = WAIT;
          default: ;
        endcase
      end
      LOOP: begin
        m_axis_tvalid = s_loop_tvalid;
        m_axis_tdata  = s_loop_tdata;
        m_axis_tlast  = s_loop_tlast;
        s_loop_tready = m_axis_tready;
        // Leave only between packets: on the closing beat, or while idle with nothing moving.
        if (cfg_mode != MODE_LOOP &&
            ((s_loop_tvalid && m_axis_tready && s_loop_tlast) ||
             (!in_pkt && !(s_loop_tvalid && m_axis_tready))))
          state_nxt = IDLE;
      end
      STIM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = base_q + DATA_WIDTH'(word_idx);
        m_axis_tlast  = stim_last;
        if (m_axis_tready && stim_last) state_nxt = IDLE;
      end
      WAIT: begin
        if (delay_cnt == '0) state_nxt = USER;
      end
      USER: begin
        m_axis_tvalid = s_user_tvalid;
        m_axis_tdata  = s_user_tdata;
        m_axis_tlast  = s_user_tlast;
        s_user_tready = m_axis_tready;
        if (s_user_tvalid && m_axis_tready && s_user_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state       <= IDLE;
      active_mode <= 2'b00;
      period_cnt  <= '0;
      pending     <= 1'b0;
      delay_cnt   <= '0;
      len_q       <= LEN_ONE;
      word_idx    <= '0;
      base_q      <= '0;
      in_pkt      <= 1'b0;
      pkt_count   <= '0;
      trig_drop   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) active_mode <= cfg_mode;

      // Period timer free-runs in stimulus mode; an expiry mid-packet is remembered once.
      if (cfg_mode != MODE_STIM) begin
        period_cnt <= '0;
        pending    <= 1'b0;
      end else begin
        period_cnt <= period_hit ? '0 : period_cnt + CNT_ONE;
        if (state == STIM && period_hit) pending <= 1'b1;
        else if (launch)                 pending <= 1'b0;
      end

      if (state == IDLE && cfg_mode == MODE_TRIG && rx_tlast) delay_cnt <= cfg_delay;
      else if (state == WAIT && delay_cnt != '0)              delay_cnt <= delay_cnt - CNT_ONE;

      if (launch) begin
        len_q    <= len_eff;
        base_q   <= cfg_base;
        word_idx <= '0;
      end else if (state == STIM && m_axis_tready) begin
        word_idx <= stim_last ? '0 : word_idx + LEN_ONE;
      end

      if (state != LOOP) in_pkt <= 1'b0;
      else if (beat)     in_pkt <= !m_axis_tlast;

      if (last_beat) pkt_count <= pkt_count + 32'd1;

      if (rx_tlast && active_mode == MODE_TRIG && (state == WAIT || state == USER) &&
          trig_drop != 16'hFFFF)
        trig_drop <= trig_drop + 16'd1;
    end
  end

endmodule

// File: tb/tb_aurora_tx_sequencer.sv
// Self-checking bench for aurora_tx_sequencer: flow-control vector table, beat scoreboard,
// and directed sequences for stimulus timing, pending launches, triggered reply, mode switch and reset.
`timescale 1ns/1ps
module tb_aurora_tx_sequencer;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cfg_mode;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_period, cfg_delay;
  logic [DW-1:0] cfg_base;
  logic          rx_tlast;
  logic          s_loop_tvalid, s_loop_tlast, s_loop_tready;
  logic [DW-1:0] s_loop_tdata;
  logic          s_user_tvalid, s_user_tlast, s_user_tready;
  logic [DW-1:0] s_user_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [1:0]    active_mode;
  logic          busy;
  logic [31:0]   pkt_count;
  logic [15:0]   trig_drop;

  always #5 clk = ~clk;

  aurora_tx_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_period(cfg_period),
    .cfg_delay(cfg_delay), .cfg_base(cfg_base), .rx_tlast(rx_tlast),
    .s_loop_tvalid(s_loop_tvalid), .s_loop_tdata(s_loop_tdata),
    .s_loop_tlast(s_loop_tlast), .s_loop_tready(s_loop_tready),
    .s_user_tvalid(s_user_tvalid), .s_user_tdata(s_user_tdata),
    .s_user_tlast(s_user_tlast), .s_user_tready(s_user_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .active_mode(active_mode), .busy(busy), .pkt_count(pkt_count), .trig_drop(trig_drop)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [1:0] mode;
    logic lv, uv, rdy, rx;
    logic e_tvalid, e_loop_rdy, e_user_rdy, e_busy;
  } vec_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  int            sop_cyc[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            exp_pkts = 0;
  logic          sop = 1'b1;
  logic          stab_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  vec_t          vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{data: base + DW'(i), last: (i == len - 1)});
      if (i == len - 1) exp_pkts++;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Beat monitor: scoreboard pops, packet-start timestamps and stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stab_en && prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_tdata", m_axis_tdata, prev_data);
        check("stall_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_beat: got tdata 0x%0h, expected no beat (t=%0t)", m_axis_tdata, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_tdata", m_axis_tdata, mon_e.data);
          check("beat_tlast", m_axis_tlast, mon_e.last);
        end
        if (sop) sop_cyc.push_back(cyc);
        sop = m_axis_tlast;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;
    logic seen;

    cfg_mode = 2'b00; cfg_len = 8'd1; cfg_period = 16'd100; cfg_delay = 16'd0; cfg_base = '0;
    rx_tlast = 1'b0; m_axis_tready = 1'b0;
    s_loop_tvalid = 1'b0; s_loop_tdata = '0; s_loop_tlast = 1'b0;
    s_user_tvalid = 1'b0; s_user_tdata = '0; s_user_tlast = 1'b0;

    //              mode   lv    uv    rdy   rx    tvalid lrdy  urdy  busy
    vecs[0] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_loop_ready", s_loop_tready, 1'b0);
    check("rst_user_ready", s_user_tready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_count", pkt_count, 32'h0);
    check("rst_trig_drop", trig_drop, 16'h0);
    check("rst_active_mode", active_mode, 2'b00);
    tick();
    rst_n = 1'b1;

    // Off mode with random stream activity
    for (int i = 0; i < 8; i++) begin
      tick();
      s_loop_tvalid = 1'($urandom_range(0, 1));
      s_loop_tlast  = 1'($urandom_range(0, 1));
      s_loop_tdata  = $urandom;
      s_user_tvalid = 1'($urandom_range(0, 1));
      s_user_tlast  = 1'($urandom_range(0, 1));
      s_user_tdata  = $urandom;
      m_axis_tready = 1'($urandom_range(0, 1));
      rx_tlast      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("off_tvalid", m_axis_tvalid, 1'b0);
      check("off_loop_ready", s_loop_tready, 1'b0);
      check("off_user_ready", s_user_tready, 1'b0);
      check("off_busy", busy, 1'b0);
    end
    check("off_pkt_count", pkt_count, 32'h0);

    // Flow-control vector table (no tlast beats anywhere)
    for (int i = 0; i < 9; i++) begin
      tick();
      cfg_mode = vecs[i].mode;
      s_loop_tvalid = vecs[i].lv; s_loop_tlast = 1'b0;
      s_user_tvalid = vecs[i].uv; s_user_tlast = 1'b0;
      m_axis_tready = vecs[i].rdy;
      rx_tlast = vecs[i].rx;
      @(negedge clk);
      check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].e_tvalid);
      check($sformatf("vec%0d_loop_ready", i), s_loop_tready, vecs[i].e_loop_rdy);
      check($sformatf("vec%0d_user_ready", i), s_user_tready, vecs[i].e_user_rdy);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end
    check("vec_trig_drop", trig_drop, 16'h0);

    // Stimulus: len 3, base 0x10, period 8, always ready
    tick();
    cfg_mode = 2'b00; s_loop_tvalid = 1'b0; s_user_tvalid = 1'b0; rx_tlast = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    sop = 1'b1; sop_cyc.delete();
    for (int p = 0; p < 3; p++) push_pkt(32'h10, 3);
    cfg_len = 8'd3; cfg_base = 32'h10; cfg_period = 16'd8; cfg_mode = 2'b10;
    wait_drain(200, "stim_drain");
    #1;
    cfg_mode = 2'b00;
    check("stim_pkt_starts", sop_cyc.size(), 3);
    if (sop_cyc.size() >= 3) begin
      check("stim_launch_gap1", sop_cyc[1] - sop_cyc[0], 8);
      check("stim_launch_gap2", sop_cyc[2] - sop_cyc[1], 8);
    end
    check("stim_pkt_count", pkt_count, exp_pkts);
    @(negedge clk);
    check("stim_idle_busy", busy, 1'b0);

    // Stimulus with toggling ready: pending launches, stall stability
    tick();
    for (int p = 0; p < 10; p++) push_pkt(32'h100, 4);
    cfg_len = 8'd4; cfg_base = 32'h100; cfg_period = 16'd2; stab_en = 1'b1; cfg_mode = 2'b10;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
      m_axis_tready = ~m_axis_tready;
    end
    cfg_mode = 2'b00;
    stab_en = 1'b0;
    check("pend_drain", exp_q.size(), 0);
    exp_q.delete();
    m_axis_tready = 1'b1;
    tick();
    check("pend_pkt_count", pkt_count, exp_pkts);

    // Triggered reply: delay 5, 4-word user packet, triggers dropped during USER
    tick();
    cfg_mode = 2'b11; cfg_delay = 16'd5; m_axis_tready = 1'b1;
    s_user_tvalid = 1'b1; s_user_tdata = 32'hA0; s_user_tlast = 1'b0;
    push_pkt(32'hA0, 4);
    tick();
    check("trig_active_mode", active_mode, 2'b11);
    rx_tlast = 1'b1;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      rx_tlast = 1'b0;
      @(negedge clk);
      seen = m_axis_tvalid;
      if (!seen) check("wait_user_ready", s_user_tready, 1'b0);
    end
    check("trig_latency_edges", edges, 7);
    tick(); s_user_tdata = 32'hA1; rx_tlast = 1'b1;
    tick(); s_user_tdata = 32'hA2; rx_tlast = 1'b0;
    tick(); s_user_tdata = 32'hA3; s_user_tlast = 1'b1; rx_tlast = 1'b1;
    tick(); s_user_tvalid = 1'b0; s_user_tlast = 1'b0; rx_tlast = 1'b0;
    @(negedge clk);
    check("trig_drop_count", trig_drop, 16'd2);
    check("trig_busy_after", busy, 1'b0);
    wait_drain(5, "trig_drain");
    #1;
    cfg_mode = 2'b00;
    check("trig_pkt_count", pkt_count, exp_pkts);

    // Loopback packet, switch to stimulus after beat 2
    tick();
    cfg_mode = 2'b01; cfg_len = 8'd2; cfg_base = 32'h200; cfg_period = 16'd5;
    push_pkt(32'hC0, 4);
    push_pkt(32'h200, 2);
    tick();
    s_loop_tvalid = 1'b1; s_loop_tdata = 32'hC0; s_loop_tlast = 1'b0;
    @(negedge clk);
    check("loop_active_mode", active_mode, 2'b01);
    check("loop_busy", busy, 1'b1);
    tick(); s_loop_tdata = 32'hC1;
    tick(); s_loop_tdata = 32'hC2; cfg_mode = 2'b10;
    tick(); s_loop_tdata = 32'hC3; s_loop_tlast = 1'b1;
    tick(); s_loop_tvalid = 1'b0; s_loop_tlast = 1'b0;
    wait_drain(60, "loop_stim_drain");
    #1;
    check("switch_active_mode", active_mode, 2'b10);
    cfg_mode = 2'b00;
    check("loop_pkt_count", pkt_count, exp_pkts);

    // Async reset in the middle of a stimulus packet
    tick();
    cfg_len = 8'd8; cfg_base = 32'h300; cfg_period = 16'd4; cfg_mode = 2'b10;
    push_pkt(32'h300, 8);
    for (int k = 0; k < 40 && !m_axis_tvalid; k++) @(negedge clk);
    check("rst_pre_tvalid", m_axis_tvalid, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_tdata", m_axis_tdata, 32'h0);
    check("midrst_tlast", m_axis_tlast, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pkt_count", pkt_count, 32'h0);
    check("midrst_trig_drop", trig_drop, 16'h0);
    check("midrst_active_mode", active_mode, 2'b00);
    exp_q.delete();
    exp_pkts = 0;
    sop = 1'b1;
    tick();
    rst_n = 1'b1;
    push_pkt(32'h300, 8);
    wait_drain(100, "post_rst_drain");
    #1;
    cfg_mode = 2'b00;
    check("post_rst_pkt_count", pkt_count, exp_pkts);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
